// File: rtl/mem_arbiter_pkg.sv
// Shared CPU defines for the memory arbiter.
// Contents: FSM state encoding, RV32 load/store func3 codes, the idle
// func3 code driven to memory when no command is active, and a helper that
// classifies a func3/address pair as misaligned.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Matches no load or store code, so memory ignores the command bus.
  localparam logic [2:0] F3_IDLE = 3'b011;

  // Store codes share their values with LB/LH/LW, so only the load names
  // appear as case items.
  function automatic logic misaligned(input logic [2:0] func3,
                                      input logic [1:0] addr_lo);
    case (func3)
      F3_LW:         return addr_lo != 2'b00;
      F3_LH, F3_LHU: return addr_lo[0];
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant (combinational).
// Ports: valid0_i/valid1_i request bits, last_grant_i = requester that won
// the previous accept; gnt0_o/gnt1_o one-hot (or zero) grant.
// A lone requester always wins; on contention the requester that did not
// win last time is granted.
module mem_arb_rr (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  assign gnt0_o = valid0_i & (~valid1_i | last_grant_i);
  assign gnt1_o = valid1_i & (~valid0_i | ~last_grant_i);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: core data port (req0) and loader/DMA port (req1)
// share one combinational-read memory. Each transaction takes three cycles:
// IDLE (accept), ACCESS (memory command), RESP (one-cycle response).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/addr/wdata/we/func3  request handshake + command, N=0,1
//   rspN_valid/rdata/err             one-cycle response to requester N
//   mem_addr/wdata/func3/write/read  memory command (idle-safe outside ACCESS)
//   mem_rdata                        combinational read data from memory
// Build option: define MEM_ARB_ALIGN_CHK_EN to suppress misaligned word and
// halfword accesses and report them through rspN_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic              req0_we,
  input  logic [2:0]        req0_func3,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic              req1_we,
  input  logic [2:0]        req1_func3,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [31:0]       rdata_q;

  logic gnt0, gnt1;
  logic idle_ok;
  logic accept0, accept1, accept;
  logic suppress;

  mem_arb_rr u_rr (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  // Ready is also held low while reset is asserted so every output reads 0.
  assign idle_ok    = (state_q == ST_IDLE) & rst_n;
  assign req0_ready = idle_ok & gnt0;
  assign req1_ready = idle_ok & gnt1;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;
  assign accept     = accept0 | accept1;

`ifdef MEM_ARB_ALIGN_CHK_EN
  logic err_q;

  assign suppress = misaligned(func3_q, addr_q[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      err_q <= suppress;
    end
  end

  assign rsp0_err = rsp0_valid & err_q;
  assign rsp1_err = rsp1_valid & err_q;
`else
  assign suppress = 1'b0;
  assign rsp0_err = 1'b0;
  assign rsp1_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The command bus is only live in an unsuppressed ACCESS; everywhere else
  // it is parked at the idle code so memory can never see a stray write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_func3 = F3_IDLE;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (state_q == ST_ACCESS && !suppress) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_func3 = func3_q;
      mem_write = we_q;
      mem_read  = ~we_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      func3_q      <= 3'b000;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= accept1;
        owner_q      <= accept1;
        addr_q       <= accept1 ? req1_addr  : req0_addr;
        wdata_q      <= accept1 ? req1_wdata : req0_wdata;
        we_q         <= accept1 ? req1_we    : req0_we;
        func3_q      <= accept1 ? req1_func3 : req0_func3;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= (we_q || suppress) ? 32'h0 : mem_rdata;
      end
    end
  end

  assign rsp0_valid = (state_q == ST_RESP) & ~owner_q;
  assign rsp1_valid = (state_q == ST_RESP) &  owner_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 32'h0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-port run
// checked against a transaction-level model (round-robin winner, 3-cycle
// occupancy, byte-array memory image).
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]             rv;
  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][31:0]       rwdata;
  logic [1:0]             rwe;
  logic [1:0][2:0]        rf3;

  logic rdy0, rdy1, rspv0, rspv1, rerr0, rerr1;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;
  logic mem_write, mem_read;

  wire [1:0] rdy  = {rdy1, rdy0};
  wire [1:0] rspv = {rspv1, rspv0};

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] dmem    [256];
  logic [7:0] ref_mem [256];
  logic       init_mem;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rv[0]), .req0_ready(rdy0), .req0_addr(raddr[0]),
    .req0_wdata(rwdata[0]), .req0_we(rwe[0]), .req0_func3(rf3[0]),
    .req1_valid(rv[1]), .req1_ready(rdy1), .req1_addr(raddr[1]),
    .req1_wdata(rwdata[1]), .req1_we(rwe[1]), .req1_func3(rf3[1]),
    .rsp0_valid(rspv0), .rsp0_rdata(rsp0_rdata), .rsp0_err(rerr0),
    .rsp1_valid(rspv1), .rsp1_rdata(rsp1_rdata), .rsp1_err(rerr1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] idx(input logic [31:0] a, input int off);
    return a[7:0] + 8'(off);
  endfunction

  // RV32 load extension applied to the four bytes starting at the address.
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural memory seen by the DUT.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i * 13 + 7);
    end else if (mem_write) begin
      case (mem_func3)
        3'b000: dmem[idx(mem_addr, 0)] <= mem_wdata[7:0];
        3'b001: begin
          dmem[idx(mem_addr, 0)] <= mem_wdata[7:0];
          dmem[idx(mem_addr, 1)] <= mem_wdata[15:8];
        end
        3'b010: begin
          dmem[idx(mem_addr, 0)] <= mem_wdata[7:0];
          dmem[idx(mem_addr, 1)] <= mem_wdata[15:8];
          dmem[idx(mem_addr, 2)] <= mem_wdata[23:16];
          dmem[idx(mem_addr, 3)] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rdata = ext({dmem[idx(mem_addr, 3)], dmem[idx(mem_addr, 2)],
                     dmem[idx(mem_addr, 1)], dmem[idx(mem_addr, 0)]}, mem_func3);
  end

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    return ext({ref_mem[idx(a, 3)], ref_mem[idx(a, 2)],
                ref_mem[idx(a, 1)], ref_mem[idx(a, 0)]}, f3);
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ref_mem[idx(a, 0)] = d[7:0];
    if (f3 == 3'b001 || f3 == 3'b010) ref_mem[idx(a, 1)] = d[15:8];
    if (f3 == 3'b010) begin
      ref_mem[idx(a, 2)] = d[23:16];
      ref_mem[idx(a, 3)] = d[31:24];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drives one request on port p and captures what the DUT does; no checks.
  task automatic issue(input int p, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output int wait_cyc, output logic rd_s, output logic wr_s,
                       output logic rspv_s, output logic other_s,
                       output logic [31:0] rdata_s, output logic err_s);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    rwe[p] = we; rf3[p] = f3; raddr[p] = a; rwdata[p] = d; rv[p] = 1'b1;
    while (!acc && n < 16) begin
      @(negedge clk);
      acc = rdy[p];
      @(posedge clk); #1;
      if (!acc) n++;
    end
    rv[p] = 1'b0;
    wait_cyc = acc ? n : -1;
    rd_s = 1'b0; wr_s = 1'b0; rspv_s = 1'b0; other_s = 1'b0;
    rdata_s = 32'h0; err_s = 1'b0;
    if (acc) begin
      @(negedge clk);
      rd_s = mem_read; wr_s = mem_write;
      @(posedge clk); #1;
      @(negedge clk);
      rspv_s  = rspv[p];
      other_s = rspv[1-p];
      rdata_s = (p == 1) ? rsp1_rdata : rsp0_rdata;
      err_s   = (p == 1) ? rerr1 : rerr0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rv = 2'b11;
    @(negedge clk);
    n_cmp++;
    if ({rdy, rspv, rerr1, rerr0, mem_write, mem_read} !== 8'h00 || mem_func3 !== 3'b011 ||
        mem_addr !== '0 || mem_wdata !== 32'h0 || rsp0_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b rspv=%b wr=%b rd=%b f3=%b addr=%h, required all 0 and f3=011",
               rdy, rspv, mem_write, mem_read, mem_func3, mem_addr);
    end
    @(posedge clk); #1;
    rv = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    int w; logic rd, wr, v, o, e; logic [31:0] q;
    issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, w, rd, wr, v, o, q, e);
    ref_store(3'b010, 32'h10, 32'hDEADBEEF);
    n_cmp++;
    if (w !== 0 || wr !== 1'b1 || rd !== 1'b0 || v !== 1'b1 || o !== 1'b0 || q !== 32'h0) begin
      n_bad++;
      $display("FAIL sw_0x10: wait=%0d wr=%b rd=%b v=%b other=%b rdata=%h, required 0 1 0 1 0 0", w, wr, rd, v, o, q);
    end
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, w, rd, wr, v, o, q, e);
    n_cmp++;
    if (w !== 0 || rd !== 1'b1 || wr !== 1'b0 || v !== 1'b1 || o !== 1'b0 ||
        q !== 32'hDEADBEEF || e !== 1'b0) begin
      n_bad++;
      $display("FAIL lw_0x10: wait=%0d rd=%b wr=%b v=%b other=%b rdata=%h err=%b, required 0 1 0 1 0 deadbeef 0",
               w, rd, wr, v, o, q, e);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy, exp_rsp;
    apply_reset();
    rwe = 2'b00; rf3[0] = 3'b010; rf3[1] = 3'b100;
    raddr[0] = 32'h40; raddr[1] = 32'h81; rv = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_rdy = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
      exp_rsp = (c % 3 != 2) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++;
      if (rdy !== exp_rdy || rspv !== exp_rsp) begin
        n_bad++;
        $display("FAIL contention_c%0d: ready=%b rsp=%b, required ready=%b rsp=%b", c, rdy, rspv, exp_rdy, exp_rsp);
      end
      @(posedge clk); #1;
    end
    rv = 2'b00;
  endtask

  task automatic test_store_load();
    int w; logic rd, wr, v, o, e; logic [31:0] q;
    issue(1, 1'b1, 3'b000, 32'h21, 32'h123456A5, w, rd, wr, v, o, q, e);
    ref_store(3'b000, 32'h21, 32'h123456A5);
    n_cmp++;
    if (wr !== 1'b1 || v !== 1'b1 || o !== 1'b0 || q !== 32'h0) begin
      n_bad++;
      $display("FAIL sb_0x21: wr=%b v=%b other=%b rdata=%h, required 1 1 0 0", wr, v, o, q);
    end
    issue(1, 1'b0, 3'b100, 32'h21, 32'h0, w, rd, wr, v, o, q, e);
    n_cmp++;
    if (v !== 1'b1 || q !== 32'h000000A5) begin
      n_bad++;
      $display("FAIL lbu_0x21: v=%b rdata=%h, required 1 000000a5", v, q);
    end
    issue(1, 1'b0, 3'b000, 32'h21, 32'h0, w, rd, wr, v, o, q, e);
    n_cmp++;
    if (v !== 1'b1 || q !== 32'hFFFFFFA5) begin
      n_bad++;
      $display("FAIL lb_0x21: v=%b rdata=%h, required 1 ffffffa5", v, q);
    end
  endtask

  task automatic test_idle();
    int diffs;
    rv = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_func3 !== 3'b011 || mem_write !== 1'b0 || mem_read !== 1'b0 || rdy !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_c%0d: f3=%b wr=%b rd=%b ready=%b, required 011 0 0 00", c, mem_func3, mem_write, mem_read, rdy);
      end
      @(posedge clk); #1;
    end
    diffs = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin
      n_bad++;
      $display("FAIL idle_mem: %0d bytes differ, required 0", diffs);
    end
  endtask

  task automatic test_misaligned();
    int w; logic rd, wr, v, o, e; logic [31:0] q;
    issue(0, 1'b1, 3'b010, 32'h02, 32'h11223344, w, rd, wr, v, o, q, e);
`ifdef MEM_ARB_ALIGN_CHK_EN
    n_cmp++;
    if (v !== 1'b1 || e !== 1'b1 || wr !== 1'b0 || q !== 32'h0) begin
      n_bad++;
      $display("FAIL sw_misaligned: v=%b err=%b wr=%b rdata=%h, required 1 1 0 0", v, e, wr, q);
    end
`else
    ref_store(3'b010, 32'h02, 32'h11223344);
    n_cmp++;
    if (v !== 1'b1 || e !== 1'b0 || wr !== 1'b1) begin
      n_bad++;
      $display("FAIL sw_misaligned: v=%b err=%b wr=%b, required 1 0 1", v, e, wr);
    end
`endif
    issue(0, 1'b0, 3'b001, 32'h21, 32'h0, w, rd, wr, v, o, q, e);
`ifdef MEM_ARB_ALIGN_CHK_EN
    n_cmp++;
    if (v !== 1'b1 || e !== 1'b1 || rd !== 1'b0 || q !== 32'h0) begin
      n_bad++;
      $display("FAIL lh_misaligned: v=%b err=%b rd=%b rdata=%h, required 1 1 0 0", v, e, rd, q);
    end
`else
    n_cmp++;
    if (v !== 1'b1 || e !== 1'b0 || rd !== 1'b1 || q !== ref_load(32'h21, 3'b001)) begin
      n_bad++;
      $display("FAIL lh_misaligned: v=%b err=%b rd=%b rdata=%h, required 1 0 1 %h",
               v, e, rd, q, ref_load(32'h21, 3'b001));
    end
`endif
    issue(1, 1'b1, 3'b111, 32'h30, 32'hCAFEF00D, w, rd, wr, v, o, q, e);
    n_cmp++;
    if (v !== 1'b1 || wr !== 1'b1 || e !== 1'b0 || o !== 1'b0) begin
      n_bad++;
      $display("FAIL undef_store: v=%b wr=%b err=%b other=%b, required 1 1 0 0", v, wr, e, o);
    end
  endtask

  task automatic test_reset_mid();
    rwe[0] = 1'b0; rf3[0] = 3'b010; raddr[0] = 32'h10; rv = 2'b01;
    @(negedge clk);
    n_cmp++;
    if (rdy !== 2'b01) begin
      n_bad++;
      $display("FAIL rstmid_accept: ready=%b, required 01", rdy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_access: mem_read=%b, required 1", mem_read);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_read !== 1'b0 || mem_func3 !== 3'b011 || rdy !== 2'b00 || rspv !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_abort: rd=%b f3=%b ready=%b rsp=%b, required 0 011 00 00", mem_read, mem_func3, rdy, rspv);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rspv !== 2'b00 || rdy !== 2'b01) begin
      n_bad++;
      $display("FAIL rstmid_release: rsp=%b ready=%b, required 00 01", rspv, rdy);
    end
    @(posedge clk); #1;
    rv = 2'b00;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (rspv !== 2'b01 || rsp0_rdata !== ref_load(32'h10, 3'b010)) begin
      n_bad++;
      $display("FAIL rstmid_rsp: rsp=%b rdata=%h, required 01 %h", rspv, rsp0_rdata, ref_load(32'h10, 3'b010));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int last_w, busy_until, due_cyc, due_port, w, sz;
    logic [31:0] due_data, got;
    logic [1:0] exp_rdy, exp_rsp;
    logic [2:0] f3;
    logic acc;
    apply_reset();
    last_w = 1; busy_until = 0; due_cyc = -1; due_port = 0; due_data = 0;
    rv = 2'b00;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rv[p] && c < 390 && $urandom_range(0, 2) == 0) begin
          rwe[p] = 1'($urandom_range(0, 1));
          if (rwe[p]) f3 = 3'($urandom_range(0, 2));
          else begin
            case ($urandom_range(0, 4))
              0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
              default: f3 = 3'b101;
            endcase
          end
          sz = (f3[1:0] == 2'b10) ? 3 : (f3[1:0] == 2'b01) ? 1 : 0;
          rf3[p] = f3;
          raddr[p] = $urandom & ~32'(sz);
          rwdata[p] = $urandom;
          rv[p] = 1'b1;
        end
      end
      @(negedge clk);
      exp_rdy = 2'b00;
      if (c >= busy_until) exp_rdy = (rv == 2'b11) ? ((last_w == 1) ? 2'b01 : 2'b10) : rv;
      exp_rsp = (c == due_cyc) ? ((due_port == 1) ? 2'b10 : 2'b01) : 2'b00;
      got = (due_port == 1) ? rsp1_rdata : rsp0_rdata;
      n_cmp++;
      if (rdy !== exp_rdy || rspv !== exp_rsp || (c == due_cyc && got !== due_data)) begin
        n_bad++;
        $display("FAIL random_c%0d: ready=%b rsp=%b rdata=%h, required ready=%b rsp=%b rdata=%h",
                 c, rdy, rspv, got, exp_rdy, exp_rsp, due_data);
      end
      acc = (exp_rdy != 2'b00);
      w = exp_rdy[1] ? 1 : 0;
      if (acc) begin
        last_w = w; busy_until = c + 3; due_cyc = c + 2; due_port = w;
        if (rwe[w]) begin
          ref_store(rf3[w], raddr[w], rwdata[w]);
          due_data = 32'h0;
        end else begin
          due_data = ref_load(raddr[w], rf3[w]);
        end
      end
      @(posedge clk); #1;
      if (acc) rv[w] = 1'b0;
    end
    rv = 2'b00;
  endtask

  task automatic test_mem_final();
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) diffs++;
    n_cmp++;
    if (diffs != 0) begin
      n_bad++;
      $display("FAIL final_mem: %0d bytes differ, required 0", diffs);
    end
  endtask

  initial begin
    rst_n = 1'b0; init_mem = 1'b1;
    rv = 2'b00; raddr = '0; rwdata = '0; rwe = 2'b00; rf3 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 13 + 7);
    @(posedge clk); #1;
    init_mem = 1'b0;
    test_reset();
    test_single_load();
    test_contention();
    test_store_load();
    test_idle();
    test_misaligned();
    test_reset_mid();
    test_random();
    test_mem_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
